// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - single-player pong game engine with registered pixel colour output
// Optional paddle-hit score counter: define PONG_SCORE_EN (score reads 0 when undefined).
module pong_engine #(
   parameter int GRID_W      = 32,
   parameter int GRID_H      = 24,
   parameter int CELL        = 20,
   parameter int PADDLE_X    = 3,
   parameter int PADDLE_LEN  = 5,
   parameter int SPEED_DIV   = 4,
   parameter int MISS_FRAMES = 60,
   parameter int CW          = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   h_count,
   input  logic [15:0]   v_count,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_serve,
   output logic [CW-1:0] red,
   output logic [CW-1:0] green,
   output logic [CW-1:0] blue,
   output logic [1:0]    state,
   output logic [7:0]    score
);
   localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
   localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
   localparam int SW = $clog2(SPEED_DIV + 1);
   localparam int MW = $clog2(MISS_FRAMES + 1);
   localparam int H0 = 144;
   localparam int V0 = 35;

   localparam logic [1:0] S_SERVE = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_MISS  = 2'd2;

   localparam logic [XW-1:0] X_MID  = XW'(GRID_W / 2);
   localparam logic [XW-1:0] X_MAX  = XW'(GRID_W - 1);
   localparam logic [XW-1:0] X_HIT  = XW'(PADDLE_X + 1);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_MID  = YW'(GRID_H / 2);
   localparam logic [YW-1:0] Y_MAX  = YW'(GRID_H - 1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);
   localparam logic [YW-1:0] P_MAX  = YW'(GRID_H - PADDLE_LEN);
   localparam logic [YW-1:0] P_INIT = YW'((GRID_H - PADDLE_LEN) / 2);
   localparam logic [YW:0]   P_SPAN = (YW+1)'(PADDLE_LEN - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SPEED_DIV - 1);
   localparam logic [MW-1:0] M_LAST = MW'(MISS_FRAMES - 1);

   logic [1:0]    up_s, dn_s, sv_s;
   logic          up, down, serve;
   logic          at_origin, at_origin_q, frame_tick;
   logic [1:0]    state_q;
   logic [XW-1:0] ball_x, nx;
   logic [YW-1:0] ball_y, ny, paddle_y;
   logic          dx_neg, dy_neg, ndx, ndy;
   logic [SW-1:0] step_cnt;
   logic [MW-1:0] miss_cnt;
   logic          step_fire, at_paddle, overlap, miss;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_s        <= '0;
         dn_s        <= '0;
         sv_s        <= '0;
         at_origin_q <= 1'b0;
         frame_tick  <= 1'b0;
      end else begin
         up_s        <= {up_s[0], btn_up};
         dn_s        <= {dn_s[0], btn_down};
         sv_s        <= {sv_s[0], btn_serve};
         at_origin_q <= at_origin;
         frame_tick  <= at_origin & ~at_origin_q;
      end
   end

   assign up        = up_s[1];
   assign down      = dn_s[1];
   assign serve     = sv_s[1];
   assign at_origin = (h_count == 16'd0) && (v_count == 16'd0);
   assign step_fire = (state_q == S_PLAY) && frame_tick && (step_cnt == S_LAST);
   assign at_paddle = dx_neg && (ball_x == X_HIT);
   assign overlap   = (ball_y >= paddle_y) && ({1'b0, ball_y} <= ({1'b0, paddle_y} + P_SPAN));

   // Edge reflections are decided per axis so a corner hit flips both.
   always_comb begin
      nx   = ball_x;
      ny   = ball_y;
      ndx  = dx_neg;
      ndy  = dy_neg;
      miss = 1'b0;
      if (!dy_neg) begin
         if (ball_y == Y_MAX) begin ny = ball_y - Y_ONE; ndy = 1'b1; end
         else ny = ball_y + Y_ONE;
      end else if (ball_y == '0) begin
         ny  = ball_y + Y_ONE;
         ndy = 1'b0;
      end else ny = ball_y - Y_ONE;
      if (!dx_neg) begin
         if (ball_x == X_MAX) begin nx = ball_x - X_ONE; ndx = 1'b1; end
         else nx = ball_x + X_ONE;
      end else if (at_paddle) begin
         if (overlap) begin nx = ball_x + X_ONE; ndx = 1'b0; end
         else miss = 1'b1;
      end else nx = ball_x - X_ONE;
      if (miss) begin
         nx  = ball_x;
         ny  = ball_y;
         ndx = dx_neg;
         ndy = dy_neg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_SERVE;
         ball_x   <= X_MID;
         ball_y   <= Y_MID;
         dx_neg   <= 1'b0;
         dy_neg   <= 1'b0;
         step_cnt <= '0;
         miss_cnt <= '0;
      end else begin
         case (state_q)
            S_SERVE: begin
               ball_x   <= X_MID;
               ball_y   <= Y_MID;
               dx_neg   <= 1'b0;
               dy_neg   <= 1'b0;
               step_cnt <= '0;
               miss_cnt <= '0;
               if (serve) state_q <= S_PLAY;
            end
            S_PLAY: begin
               miss_cnt <= '0;
               if (frame_tick) begin
                  if (step_cnt == S_LAST) begin
                     step_cnt <= '0;
                     if (miss) state_q <= S_MISS;
                     ball_x <= nx;
                     ball_y <= ny;
                     dx_neg <= ndx;
                     dy_neg <= ndy;
                  end else step_cnt <= step_cnt + SW'(1);
               end
            end
            S_MISS: begin
               step_cnt <= '0;
               if (frame_tick) begin
                  if (miss_cnt == M_LAST) begin
                     state_q  <= S_SERVE;
                     miss_cnt <= '0;
                     ball_x   <= X_MID;
                     ball_y   <= Y_MID;
                     dx_neg   <= 1'b0;
                     dy_neg   <= 1'b0;
                  end else miss_cnt <= miss_cnt + MW'(1);
               end
            end
            default: state_q <= S_SERVE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) paddle_y <= P_INIT;
      else if (frame_tick) begin
         if (up && !down && paddle_y != '0) paddle_y <= paddle_y - Y_ONE;
         else if (down && !up && paddle_y < P_MAX) paddle_y <= paddle_y + Y_ONE;
      end
   end

`ifdef PONG_SCORE_EN
   logic [7:0] score_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) score_q <= 8'd0;
      else if (step_fire && at_paddle && overlap && score_q != 8'hFF) score_q <= score_q + 8'd1;
   end
   assign score = score_q;
`else
   assign score = 8'd0;
`endif

   assign state = state_q;

   logic [31:0] hx, vy, bx0, by0, px0, py0;
   logic        active, in_ball, in_paddle;

   assign hx        = 32'(h_count);
   assign vy        = 32'(v_count);
   assign bx0       = 32'(H0) + 32'(CELL) * 32'(ball_x);
   assign by0       = 32'(V0) + 32'(CELL) * 32'(ball_y);
   assign px0       = 32'(H0) + 32'(CELL) * 32'(PADDLE_X);
   assign py0       = 32'(V0) + 32'(CELL) * 32'(paddle_y);
   assign active    = (hx >= 32'd144) && (hx <= 32'd783) && (vy >= 32'd35) && (vy <= 32'd514);
   assign in_ball   = (hx >= bx0) && (hx < bx0 + 32'(CELL)) && (vy >= by0) && (vy < by0 + 32'(CELL));
   assign in_paddle = (hx >= px0) && (hx < px0 + 32'(CELL)) && (vy >= py0) &&
                      (vy < py0 + 32'(CELL) * 32'(PADDLE_LEN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (!active) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (in_ball && state_q == S_MISS) begin
         red   <= '1;
         green <= '0;
         blue  <= '0;
      end else if (in_ball || in_paddle) begin
         red   <= '1;
         green <= '1;
         blue  <= '1;
      end else begin
         red   <= CW'(2);
         green <= CW'(2);
         blue  <= '1;
      end
   end
endmodule

// File: tb/tb_pong_engine.sv
// tb/tb_pong_engine.sv - directed self-checking bench for pong_engine
module tb_pong_engine;
   logic        clk = 1'b0;
   logic        rst_n, rst2_n;
   logic [15:0] h_count, v_count;
   logic        btn_up, btn_down, btn_serve, serve2;
   logic [2:0]  red, green, blue, red2, green2, blue2;
   logic [1:0]  state, state2;
   logic [7:0]  score, score2;
   int          checks = 0;
   int          errors = 0;

`ifdef PONG_SCORE_EN
   localparam int SC = 1;
`else
   localparam int SC = 0;
`endif

   localparam int WHITE = 511;
   localparam int RED   = 448;
   localparam int BG    = 151;

   always #5 clk = ~clk;

   pong_engine dut (
      .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
      .btn_up(btn_up), .btn_down(btn_down), .btn_serve(btn_serve),
      .red(red), .green(green), .blue(blue), .state(state), .score(score)
   );

   // Small always-hit arena: fast corner reflection and score saturation.
   pong_engine #(.GRID_W(16), .GRID_H(16), .PADDLE_LEN(16), .SPEED_DIV(1)) dut2 (
      .clk(clk), .rst_n(rst2_n), .h_count(h_count), .v_count(v_count),
      .btn_up(btn_up), .btn_down(btn_down), .btn_serve(serve2),
      .red(red2), .green(green2), .blue(blue2), .state(state2), .score(score2)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         @(negedge clk);
         h_count = 16'd0;
         v_count = 16'd0;
         @(negedge clk);
         h_count = 16'd1;
         v_count = 16'd1;
         @(negedge clk);
      end
   endtask

   task automatic ball(input string tag, input int x, input int y, input int dxn, input int dyn);
      chk({tag, "_x"}, int'(dut.ball_x), x);
      chk({tag, "_y"}, int'(dut.ball_y), y);
      chk({tag, "_dx"}, int'(dut.dx_neg), dxn);
      chk({tag, "_dy"}, int'(dut.dy_neg), dyn);
   endtask

   task automatic ball2(input string tag, input int x, input int y, input int dxn, input int dyn);
      chk({tag, "_x"}, int'(dut2.ball_x), x);
      chk({tag, "_y"}, int'(dut2.ball_y), y);
      chk({tag, "_dx"}, int'(dut2.dx_neg), dxn);
      chk({tag, "_dy"}, int'(dut2.dy_neg), dyn);
   endtask

   task automatic pix(input string tag, input int h, input int v, input int exp);
      @(negedge clk);
      h_count = 16'(h);
      v_count = 16'(v);
      @(negedge clk);
      chk(tag, int'({red, green, blue}), exp);
      h_count = 16'd1;
      v_count = 16'd1;
   endtask

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      h_count = 16'd1; v_count = 16'd1;
      btn_up = 1'b0; btn_down = 1'b0; btn_serve = 1'b0; serve2 = 1'b0;
      idle(3);
      chk("rst_state", int'(state), 0);
      chk("rst_rgb", int'({red, green, blue}), 0);
      chk("rst_score", int'(score), 0);
      rst_n = 1'b1;
      frames(3);
      chk("idle_state", int'(state), 0);
      ball("idle", 16, 12, 0, 0);
      chk("idle_paddle", int'(dut.paddle_y), 9);
      chk("idle_score", int'(score), 0);

      btn_up = 1'b1; idle(2);
      frames(5);  chk("up5", int'(dut.paddle_y), 4);
      frames(15); chk("up20", int'(dut.paddle_y), 0);
      btn_down = 1'b1; idle(2);
      frames(3);  chk("both_top", int'(dut.paddle_y), 0);
      btn_up = 1'b0; idle(2);
      frames(25); chk("down_bottom", int'(dut.paddle_y), 19);
      btn_up = 1'b1; idle(2);
      frames(3);  chk("both_bottom", int'(dut.paddle_y), 19);
      btn_down = 1'b0; idle(2);
      frames(11); chk("up_to_8", int'(dut.paddle_y), 8);
      btn_up = 1'b0; idle(2);

      btn_serve = 1'b1; idle(3);
      chk("serve_play", int'(state), 1);
      btn_serve = 1'b0; idle(2);
      frames(3);  ball("no_step_yet", 16, 12, 0, 0);
      frames(1);  ball("step1", 17, 13, 0, 0);
      frames(40); ball("step11", 27, 23, 0, 0);
      frames(4);  ball("bottom_reflect", 28, 22, 0, 1);
      frames(12); ball("step15", 31, 19, 0, 1);
      frames(4);  ball("right_reflect", 30, 18, 1, 1);
      frames(104); ball("step42", 4, 8, 1, 0);
      frames(4);  ball("paddle_hit", 5, 9, 0, 0);
      chk("hit_state", int'(state), 1);
      chk("hit_score", int'(score), SC);

      pix("ball_edge", 244, 234, WHITE);
      pix("left_of_ball", 243, 234, BG);
      pix("paddle_top", 223, 195, WHITE);
      pix("paddle_bottom", 210, 294, WHITE);
      pix("below_paddle", 210, 295, BG);
      pix("active_corner", 783, 514, BG);
      pix("right_blank", 784, 514, 0);
      pix("left_blank", 143, 300, 0);

      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(state), 0);
      ball("async_rst", 16, 12, 0, 0);
      chk("async_rst_paddle", int'(dut.paddle_y), 9);
      chk("async_rst_score", int'(score), 0);
      idle(2);
      rst_n = 1'b1;

      btn_down = 1'b1; idle(2);
      frames(6);  chk("down_to_15", int'(dut.paddle_y), 15);
      btn_down = 1'b0; idle(2);
      btn_serve = 1'b1; idle(3);
      chk("reserve_play", int'(state), 1);
      btn_serve = 1'b0; idle(2);
      frames(168); ball("miss_approach", 4, 8, 1, 0);
      chk("pre_miss_state", int'(state), 1);
      frames(4);
      chk("miss_state", int'(state), 2);
      ball("miss_frozen", 4, 8, 1, 0);
      chk("miss_score", int'(score), 0);
      pix("miss_ball_red", 224, 195, RED);
      btn_serve = 1'b1; idle(4);
      chk("serve_ignored", int'(state), 2);
      btn_serve = 1'b0; idle(2);
      frames(59);
      chk("miss_59", int'(state), 2);
      ball("miss_59", 4, 8, 1, 0);
      frames(1);
      chk("miss_done", int'(state), 0);
      ball("back_to_serve", 16, 12, 0, 0);

      rst2_n = 1'b1; idle(2);
      serve2 = 1'b1; idle(3);
      chk("d2_play", int'(state2), 1);
      serve2 = 1'b0; idle(2);
      frames(7);  ball2("d2_pre_corner", 15, 15, 0, 0);
      frames(1);  ball2("d2_corner", 14, 14, 1, 1);
      frames(10); ball2("d2_step18", 4, 4, 1, 1);
      chk("d2_score0", int'(score2), 0);
      frames(1);  ball2("d2_hit", 5, 3, 0, 1);
      chk("d2_score1", int'(score2), SC);
      frames(5587);
      chk("d2_score254", int'(score2), SC * 254);
      frames(94);
      chk("d2_score_sat", int'(score2), SC * 255);
      chk("d2_still_play", int'(state2), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pong_engine.md
PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 Parameter GRID_W, default 32: playfield width in cells.
REQ-002 Parameter GRID_H, default 24: playfield height in cells.
REQ-003 Parameter CELL, default 20: cell edge in pixels.
REQ-004 Parameter PADDLE_X, default 3: paddle column.
REQ-005 Parameter PADDLE_LEN, default 5: paddle height in cells.
REQ-006 Parameter SPEED_DIV, default 4: frame ticks per ball step (>=1).
REQ-007 Parameter MISS_FRAMES, default 60: frames held in MISS.
REQ-008 Parameter CW, default 3: colour channel width.
REQ-009 clk  in  1  pixel-rate clock; single clock domain.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 h_count  in  16  horizontal pixel counter; active video 144..783.
REQ-012 v_count  in  16  vertical line counter; active video 35..514.
REQ-013 btn_up, btn_down, btn_serve  in  1 each  raw asynchronous buttons.
REQ-014 red, green, blue  out  CW each  pixel colour.
REQ-015 state  out  2  FSM state: 0 SERVE, 1 PLAY, 2 MISS.
REQ-016 score  out  8  paddle-hit count.

Function
REQ-017 Each button SHALL pass a 2-flop synchroniser; all logic uses synchronised values.
REQ-018 frame_tick SHALL be a one-cycle pulse in the cycle after h_count==0 and v_count==0 is first sampled.
REQ-019 Paddle, per frame_tick: up only if btn_up, !btn_down and paddle_y>0; down only if btn_down, !btn_up and paddle_y<GRID_H-PADDLE_LEN; both pressed or neither: hold.
REQ-020 Step counter SHALL count frame_ticks in PLAY only; ball steps when it reaches SPEED_DIV-1, then clears; clears on leaving PLAY.
REQ-021 SERVE: ball at (GRID_W/2, GRID_H/2), dx=+1, dy=+1; on btn_serve go PLAY.
REQ-022 PLAY step, vertical: if ball_y+dy leaves [0,GRID_H-1], negate dy and move opposite; else ball_y+=dy.
REQ-023 PLAY step, horizontal: ball_x==GRID_W-1 with dx=+1 negates dx (moves to GRID_W-2).
REQ-024 PLAY step, paddle: ball_x==PADDLE_X+1, dx=-1, ball_y in [paddle_y, paddle_y+PADDLE_LEN-1] -> dx=+1, ball moves right, score+1 saturating at 255.
REQ-025 PLAY step, miss: ball_x==PADDLE_X+1, dx=-1, no overlap -> MISS; ball freezes.
REQ-026 Corner case: vertical and horizontal reflection in the same step SHALL both apply.
REQ-027 MISS SHALL hold MISS_FRAMES frame_ticks, then SERVE; btn_serve ignored in MISS.
REQ-028 Ball/paddle hit test: pixel in [144+CELL*x, 144+CELL*(x+1)-1] and corresponding vertical range offset 35; paddle spans PADDLE_LEN cells.
REQ-029 Colour: paddle or ball -> all channels max; ball in MISS -> red max, green/blue 0; background -> red=green=2, blue max; outside active video -> 0.
REQ-030 red/green/blue SHALL be registered, one cycle latency from h_count/v_count.
REQ-031 Cell coordinates SHALL use minimal widths from $clog2(GRID_W), $clog2(GRID_H); position arithmetic never wraps.

Reset
REQ-032 rst_n low SHALL immediately force: state SERVE, score 0, RGB 0, ball centre, dx=dy=+1, paddle_y=(GRID_H-PADDLE_LEN)/2, counters and synchronisers 0.
REQ-033 Reset mid-PLAY or mid-MISS SHALL discard all motion; first post-reset frame starts in SERVE.

Configuration
REQ-034 With PONG_SCORE_EN defined, score behaves per REQ-024; without it, score is constant 0 and its counter is absent.

Verification
REQ-035 Reset release, no buttons, 3 frames -> state 0, ball (16,12), paddle_y 9, score 0.
REQ-036 btn_serve, ball (4,10) dx=-1, paddle_y 9 -> next step dx=+1, ball_x 5, score 1.
REQ-037 Same but paddle_y 15 -> state 2 for 60 frames, ball red, then state 0.
REQ-038 btn_up held 20 frames from paddle_y 9 -> paddle_y reaches 0, stays 0; both buttons -> no movement.
REQ-039 Ball (31,23) dx=+1 dy=+1 step -> (30,22), dx=-1, dy=-1.
REQ-040 score 255 plus a hit -> stays 255; without PONG_SCORE_EN score 0 throughout.
